seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the hex-to-seven-segment encoder: monitors a time-multiplexed, active-low seven-segment display bus (segment lines plus per-digit enables).
- Recovers the hex nibble shown on each digit and assembles a full multi-digit frame.
- Presents the frame on a valid/ready interface.
- Used as a display-bus checker/snooper and for loopback verification of display drivers.

---
 rtl/seg_scan_decoder.sv | 256 +++++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Snoops a time-multiplexed, active-low seven-segment display bus and
// recovers the hex nibble shown on each digit. When every digit has been
// seen once, the assembled frame is offered on a valid/ready interface.
// Typical uses are display-bus checking and loopback testing of display
// drivers.
//
// Parameters:
//   DIGITS         number of multiplexed digits (1..8), frame is 4*DIGITS bits
//   STABLE_CYCLES  identical consecutive samples needed to accept a digit (2..15)
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   seg_n[6:0]      segment lines, active-low, order {g,f,e,d,c,b,a}
//   an_n[DIGITS-1:0] digit enables, active-low, bit i selects digit i
//   frame_data      recovered nibbles, digit i in bits [4i+3:4i]
//   frame_bad_mask  bit i set when digit i was not a legal hex glyph
//   frame_err       OR of frame_bad_mask while frame_valid is high
//   frame_valid     a frame is available
//   frame_ready     consumer accepts the frame
//   overrun         sticky: a completed frame was dropped (output still busy)
//   err_clr         single-cycle clear of overrun (a same-cycle set wins)
//   bad_count[7:0]  only with SEG_ERR_COUNT_EN: saturating count of accepted
//                   illegal digits, cleared by err_clr (increment wins)
//
// Optional feature macro: SEG_ERR_COUNT_EN
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_bad_mask,
  output logic                  frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun,
  input  logic                  err_clr
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0]            bad_count
`endif
);

  // Counter value seen on the edge *before* the accepting edge. Accepting
  // when the counter moves from here to STABLE_CYCLES-1 gives a single
  // accept per stable pattern; further increments saturate past it.
  localparam logic [3:0] ACCEPT_CNT = 4'(STABLE_CYCLES - 2);

  typedef enum logic {
    COLLECT = 1'b0,   // no frame pending, gathering digits
    PENDING = 1'b1    // frame_valid high, gathering the next frame
  } state_e;

  // -------------------------------------------------------------------------
  // Glyph decoder: returns {illegal, nibble}. Blank and any non-hex pattern
  // decode to nibble 0 with the illegal flag set.
  // -------------------------------------------------------------------------
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b0, 4'h0};
      7'h79:   r = {1'b0, 4'h1};
      7'h24:   r = {1'b0, 4'h2};
      7'h30:   r = {1'b0, 4'h3};
      7'h19:   r = {1'b0, 4'h4};
      7'h12:   r = {1'b0, 4'h5};
      7'h02:   r = {1'b0, 4'h6};
      7'h78:   r = {1'b0, 4'h7};
      7'h00:   r = {1'b0, 4'h8};
      7'h18:   r = {1'b0, 4'h9};
      7'h08:   r = {1'b0, 4'hA};
      7'h03:   r = {1'b0, 4'hB};
      7'h46:   r = {1'b0, 4'hC};
      7'h21:   r = {1'b0, 4'hD};
      7'h06:   r = {1'b0, 4'hE};
      7'h0E:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0]   an_q,      an_d;
  logic [6:0]          seg_q,     seg_d;
  logic [3:0]          cnt_q,     cnt_d;
  logic [4*DIGITS-1:0] slots_q,   slots_d;
  logic [DIGITS-1:0]   seen_q,    seen_d;
  logic [DIGITS-1:0]   bad_q,     bad_d;
  logic [4*DIGITS-1:0] data_q,    data_d;
  logic [DIGITS-1:0]   mask_q,    mask_d;
  logic                overrun_q, overrun_d;
  state_e              state_q,   state_d;

  // -------------------------------------------------------------------------
  // Sample stage and stability tracking
  // -------------------------------------------------------------------------
  logic [3:0] low_cnt;
  logic       one_low;
  logic       same_sample;
  logic       stable_inc;
  logic       accept;
  logic [4:0] glyph;
  logic       glyph_bad;
  logic [3:0] glyph_nib;

  // NOTE: every signal driven here gets a default before any condition, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    an_d    = an_n;
    seg_d   = seg_n;
    low_cnt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) low_cnt = low_cnt + 4'd1;
    end
    one_low = (low_cnt == 4'd1);

    // The incoming sample is compared with the registered one; the pattern
    // itself is taken from the registered copy (they are equal whenever
    // the counter advances).
    same_sample = (an_n == an_q) && (seg_n == seg_q);
    stable_inc  = same_sample && one_low;

    if (!stable_inc)          cnt_d = '0;
    else if (cnt_q == 4'hF)   cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 4'd1;

    accept    = stable_inc && (cnt_q == ACCEPT_CNT);
    glyph     = decode_glyph(seg_q);
    glyph_bad = glyph[4];
    glyph_nib = glyph[3:0];
  end

  // -------------------------------------------------------------------------
  // Frame assembly and output controller
  // -------------------------------------------------------------------------
  logic [4*DIGITS-1:0] slots_merge;
  logic [DIGITS-1:0]   seen_merge;
  logic [DIGITS-1:0]   bad_merge;
  logic                complete;
  logic                out_free;

  always_comb begin
    slots_merge = slots_q;
    seen_merge  = seen_q;
    bad_merge   = bad_q;
    if (accept) begin
      for (int i = 0; i < DIGITS; i++) begin
        // an_q is known one-hot-low whenever accept is high.
        if (!an_q[i]) begin
          slots_merge[4*i +: 4] = glyph_nib;
          seen_merge[i]         = 1'b1;
          bad_merge[i]          = glyph_bad;
        end
      end
    end

    // Completion includes the digit being accepted this very cycle.
    complete = accept && (&seen_merge);
    // The output register may be reloaded if empty or being drained now.
    out_free = (state_q == COLLECT) || frame_ready;

    state_d   = state_q;
    slots_d   = slots_merge;
    seen_d    = seen_merge;
    bad_d     = bad_merge;
    data_d    = data_q;
    mask_d    = mask_q;
    overrun_d = overrun_q && !err_clr;

    if (complete) begin
      seen_d = '0;
      bad_d  = '0;
      if (out_free) begin
        data_d  = slots_merge;
        mask_d  = bad_merge;
        state_d = PENDING;
      end else begin
        // Previous frame not yet taken: drop the new one; set beats err_clr.
        overrun_d = 1'b1;
      end
    end else if ((state_q == PENDING) && frame_ready) begin
      state_d = COLLECT;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every flop sees the pre-edge values of the others.
  // NOTE: the digit slots are plain flops, not a RAM, and are cleared on
  // reset so a restarted scan can never expose nibbles from before reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q      <= '0;
      seg_q     <= '0;
      cnt_q     <= '0;
      slots_q   <= '0;
      seen_q    <= '0;
      bad_q     <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
      state_q   <= COLLECT;
    end else begin
      an_q      <= an_d;
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
      slots_q   <= slots_d;
      seen_q    <= seen_d;
      bad_q     <= bad_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign frame_valid    = (state_q == PENDING);
  assign frame_data     = data_q;
  assign frame_bad_mask = mask_q;
  assign frame_err      = frame_valid && (|mask_q);
  assign overrun        = overrun_q;

`ifdef SEG_ERR_COUNT_EN
  // -------------------------------------------------------------------------
  // Illegal-glyph counter
  // -------------------------------------------------------------------------
  logic [7:0] bad_count_q, bad_count_d;

  always_comb begin
    bad_count_d = bad_count_q;
    if (accept && glyph_bad) begin
      // Increment has priority over err_clr.
      if (bad_count_q != 8'hFF) bad_count_d = bad_count_q + 8'd1;
    end else if (err_clr) begin
      bad_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bad_count_q <= '0;
    else        bad_count_q <= bad_count_d;
  end

  assign bad_count = bad_count_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Directed bench for seg_scan_decoder with default parameters (4 digits,
// 3 stable cycles). Inputs are driven 2 time units after a rising edge and
// checked there; a monitor on the falling edge records every accepted frame.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] frame_data;
  logic [3:0]  frame_bad_mask;
  logic        frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
  logic        err_clr;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0]  bad_count;
`endif

  int checks = 0;
  int errors = 0;

  // Frame monitor: counts handshakes and captures the transferred frame.
  int          vcount = 0;
  logic [15:0] cap_data = '0;
  logic [3:0]  cap_bad  = '0;
  logic        cap_err  = 1'b0;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .DIGITS        (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .seg_n          (seg_n),
    .an_n           (an_n),
    .frame_data     (frame_data),
    .frame_bad_mask (frame_bad_mask),
    .frame_err      (frame_err),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .overrun        (overrun),
    .err_clr        (err_clr)
`ifdef SEG_ERR_COUNT_EN
    ,
    .bad_count      (bad_count)
`endif
  );

  always @(negedge clk) begin
    if (frame_valid && frame_ready) begin
      vcount++;
      cap_data = frame_data;
      cap_bad  = frame_bad_mask;
      cap_err  = frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bus pattern for n rising edges; returns 2 units after the last.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an_n  = a;
    seg_n = s;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    hold(4'hF, 7'h7F, n);
  endtask

  // One full scan: digit 0..3 for 4 cycles each, then a short blank gap.
  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(4'hE, s0, 4);
    hold(4'hD, s1, 4);
    hold(4'hB, s2, 4);
    hold(4'h7, s3, 4);
    idle(2);
  endtask

  int v;

  initial begin
    rst_n       = 1'b0;
    an_n        = 4'hF;
    seg_n       = 7'h7F;
    frame_ready = 1'b1;
    err_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // ---- reset state ----
    check("rst_valid",   frame_valid,    0);
    check("rst_data",    frame_data,     0);
    check("rst_mask",    frame_bad_mask, 0);
    check("rst_err",     frame_err,      0);
    check("rst_overrun", overrun,        0);

    // ---- basic scan 0,1,2,3 with latency of the last digit ----
    hold(4'hE, 7'h40, 4);
    hold(4'hD, 7'h79, 4);
    hold(4'hB, 7'h24, 4);
    hold(4'h7, 7'h30, 2);
    check("lat_before_valid", frame_valid, 0);
    hold(4'h7, 7'h30, 1);
    check("lat_valid_rise", frame_valid, 1);
    check("lat_data",       frame_data, 16'h3210);
    check("lat_mask",       frame_bad_mask, 0);
    check("lat_err",        frame_err, 0);
    hold(4'h7, 7'h30, 1);
    check("pulse_drop",     frame_valid, 0);
    idle(2);
    check("basic_count", vcount, 1);
    check("basic_data",  cap_data, 16'h3210);

    // ---- blank on digit 2 ----
    scan4(7'h40, 7'h79, 7'h7F, 7'h30);
    check("blank_count", vcount, 2);
    check("blank_data",  cap_data, 16'h3010);
    check("blank_mask",  cap_bad, 4'b0100);
    check("blank_err",   cap_err, 1);

    // ---- digit 1 too short, then rescanned ----
    v = vcount;
    hold(4'hE, 7'h40, 4);
    hold(4'hD, 7'h79, 2);
    hold(4'hB, 7'h24, 4);
    hold(4'h7, 7'h30, 4);
    idle(3);
    check("short_no_frame", vcount, v);
    check("short_valid",    frame_valid, 0);
    hold(4'hD, 7'h79, 4);
    idle(2);
    check("rescan_count", vcount, v + 1);
    check("rescan_data",  cap_data, 16'h3210);

    // ---- back-pressure, overrun and err_clr ----
    frame_ready = 1'b0;
    scan4(7'h08, 7'h03, 7'h46, 7'h21);
    check("bp_valid",   frame_valid, 1);
    check("bp_data",    frame_data, 16'hDCBA);
    check("bp_overrun0", overrun, 0);
    scan4(7'h06, 7'h0E, 7'h40, 7'h79);
    check("ovr_valid",  frame_valid, 1);
    check("ovr_data",   frame_data, 16'hDCBA);
    check("ovr_mask",   frame_bad_mask, 0);
    check("ovr_flag",   overrun, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("clr_overrun", overrun, 0);
    check("clr_data",    frame_data, 16'hDCBA);
    check("clr_valid",   frame_valid, 1);
    v = vcount;
    frame_ready = 1'b1;
    idle(1);
    check("drain_valid", frame_valid, 0);
    check("drain_count", vcount, v + 1);
    check("drain_data",  cap_data, 16'hDCBA);

    // ---- glyphs E, F, B, D ----
    scan4(7'h06, 7'h0E, 7'h03, 7'h21);
    check("ef_count", vcount, v + 2);
    check("ef_data",  cap_data, 16'hDBFE);
    check("ef_mask",  cap_bad, 0);

    // ---- two digits enabled at once ----
    v = vcount;
    hold(4'b1100, 7'h40, 10);
    hold(4'hB, 7'h24, 4);
    hold(4'h7, 7'h30, 4);
    idle(2);
    check("multi_no_frame", vcount, v);
    hold(4'hE, 7'h19, 4);
    hold(4'hD, 7'h12, 4);
    idle(2);
    check("multi_count", vcount, v + 1);
    check("multi_data",  cap_data, 16'h3254);

    // ---- reset mid-scan ----
    hold(4'hE, 7'h40, 4);
    hold(4'hD, 7'h79, 4);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    rst_n = 1'b0;
    #2;
    check("async_rst_data", frame_data, 0);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_valid",   frame_valid, 0);
    check("post_rst_overrun", overrun, 0);
    v = vcount;
    hold(4'hB, 7'h02, 4);
    hold(4'h7, 7'h78, 4);
    idle(2);
    check("rst_partial_lost", vcount, v);
    hold(4'hE, 7'h00, 4);
    hold(4'hD, 7'h18, 4);
    idle(2);
    check("post_rst_count", vcount, v + 1);
    check("post_rst_data",  cap_data, 16'h7698);

`ifdef SEG_ERR_COUNT_EN
    // ---- illegal glyph counter ----
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("cnt_cleared", bad_count, 0);
    scan4(7'h7F, 7'h7F, 7'h7F, 7'h40);
    check("cnt_three", bad_count, 3);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("cnt_clr", bad_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
